// File: rtl/matrix_pkg.sv
// matrix_pkg: shared word width and server FSM encodings for the matrix engine
package matrix_pkg;
  localparam int WORD_W = 32;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/mem_dualport.sv
// mem_dualport: word array with two write ports (port a wins) and two async read ports
module mem_dualport #(
  parameter int DEPTH = 64,
  parameter int W = 32,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [W-1:0]  a_wdata,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [W-1:0]  b_wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [W-1:0]  ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [W-1:0]  rb_data
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_wdata;
    if (a_we) mem[a_addr] <= a_wdata;
  end
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
endmodule

// File: rtl/matrix_mem_server.sv
// matrix_mem_server: fixed-latency word memory serving the multiply engine plus a host preload port
module matrix_mem_server
  import matrix_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_memory_transaction,
  input  logic                     we,
  input  logic [31:0]              address_in,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata,
  output logic                     done_memory_transaction,
  output logic                     err,
  input  logic                     host_we,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [WORD_W-1:0]        host_wdata,
  output logic [WORD_W-1:0]        host_rdata
);
  localparam int AW = $clog2(DEPTH);
  logic [1:0] state;
  logic [3:0] cnt;
  logic cap_we;
  logic [31:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [WORD_W-1:0] mem_rd;
  logic [WORD_W-1:0] host_rd;
  logic valid;
  logic finish;
  assign valid = (cap_addr[1:0] == 2'b00) && (cap_addr[31:2] < 30'(DEPTH));
  assign finish = (state == ST_BUSY) && (cnt == 4'd0);
  assign done_memory_transaction = (state == ST_DONE);
  mem_dualport #(.DEPTH(DEPTH), .W(WORD_W)) u_mem (
    .clk    (clk),
    .a_we   (finish && cap_we && valid),
    .a_addr (cap_addr[AW+1:2]),
    .a_wdata(cap_wdata),
    .b_we   (host_we),
    .b_addr (host_addr),
    .b_wdata(host_wdata),
    .ra_addr(cap_addr[AW+1:2]),
    .ra_data(mem_rd),
    .rb_addr(host_addr),
    .rb_data(host_rd)
  );
  // memory side effects happen only on the BUSY->DONE edge, so a reset before it aborts cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= 4'd0;
      rdata <= '0;
      err <= 1'b0;
      host_rdata <= '0;
      cap_we <= 1'b0;
      cap_addr <= '0;
      cap_wdata <= '0;
    end else begin
      host_rdata <= host_rd;
      if (state == ST_IDLE && start_memory_transaction) begin
        state <= ST_BUSY;
        cnt <= 4'(LAT - 1);
        cap_we <= we;
        cap_addr <= address_in;
        cap_wdata <= wdata;
      end else if (finish) begin
        state <= ST_DONE;
        err <= !valid;
        if (!valid) rdata <= '0;
        else if (!cap_we) rdata <= mem_rd;
      end else if (state == ST_BUSY) begin
        cnt <= cnt - 4'd1;
      end else if (state == ST_DONE) begin
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_matrix_mem_server.sv
// tb_matrix_mem_server: scoreboard bench for the fixed-latency memory server
module tb_matrix_mem_server;
  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic we = 0;
  logic [31:0] address_in = 0;
  logic [31:0] wdata = 0;
  logic [31:0] rdata;
  logic done;
  logic err;
  logic host_we = 0;
  logic [5:0] host_addr = 0;
  logic [31:0] host_wdata = 0;
  logic [31:0] host_rdata;
  int n_chk = 0;
  int n_fail = 0;
  logic [32:0] sb[$];

  matrix_mem_server dut (
    .clk(clk), .rst_n(rst_n), .start_memory_transaction(start), .we(we),
    .address_in(address_in), .wdata(wdata), .rdata(rdata),
    .done_memory_transaction(done), .err(err), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      check("sb_has_entry", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [32:0] e;
        e = sb.pop_front();
        check("rdata", rdata, e[32:1]);
        check("err", 32'(err), 32'(e[0]));
      end
    end
  end

  task automatic host_wr(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk) begin host_we = 1; host_addr = a; host_wdata = d; end
    @(negedge clk) host_we = 0;
  endtask

  task automatic host_rd(input string tag, input logic [5:0] a, input logic [31:0] exp);
    @(negedge clk) host_addr = a;
    @(negedge clk) check(tag, host_rdata, exp);
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] er, input logic ee, input logic hw = 0,
                     input logic [5:0] ha = 0, input logic [31:0] hd = 0);
    int lat;
    sb.push_back({er, ee});
    @(negedge clk) begin start = 1; we = w; address_in = a; wdata = d; end
    @(negedge clk) start = 0;
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      if (lat == 2 && hw) begin host_we = 1; host_addr = ha; host_wdata = hd; end
      if (lat == 3) host_we = 0;
    end
    host_we = 0;
    check("latency", lat, 3);
  endtask

  initial begin
    int pulses;
    int last;
    int seen;
    #1;
    check("rst_rdata", rdata, 0);
    check("rst_err", 32'(err), 0);
    check("rst_done", 32'(done), 0);
    check("rst_host_rdata", host_rdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    host_wr(3, 32'h5);
    txn(0, 32'h0C, 0, 32'h5, 0);
    txn(1, 32'h10, 32'hDEAD_BEEF, 32'h5, 0);
    host_rd("wr_readback", 4, 32'hDEAD_BEEF);
    txn(0, 32'h0E, 0, 0, 1);
    host_rd("misalign_word3", 3, 32'h5);
    txn(0, 32'h100, 0, 0, 1);
    host_wr(0, 32'hAAAA_0000);
    txn(1, 32'h100, 32'h1234_5678, 0, 1);
    host_rd("oor_word0", 0, 32'hAAAA_0000);
    txn(1, 32'h11, 32'h1234_5678, 0, 1);
    host_rd("misalign_wr_word4", 4, 32'hDEAD_BEEF);
    txn(0, 32'h10, 0, 32'hDEAD_BEEF, 0);
    // request held high: expect five completions spaced LAT+2 apart
    repeat (5) sb.push_back({32'h5, 1'b0});
    @(negedge clk) begin start = 1; we = 0; address_in = 32'h0C; end
    pulses = 0;
    last = -1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i == 19) start = 0;
      if (done) begin
        if (last >= 0) check("b2b_gap", i - last, 4);
        last = i;
        pulses++;
      end
    end
    check("b2b_count", pulses, 5);
    host_wr(2, 32'h1234);
    @(negedge clk) begin start = 1; we = 1; address_in = 32'h08; wdata = 32'hFFFF_FFFF; end
    @(negedge clk) begin start = 0; rst_n = 0; end
    #1;
    check("abort_rdata", rdata, 0);
    check("abort_err", 32'(err), 0);
    check("abort_done", 32'(done), 0);
    check("abort_host_rdata", host_rdata, 0);
    @(negedge clk) rst_n = 1;
    seen = 0;
    repeat (6) @(negedge clk) if (done) seen++;
    check("abort_no_done", seen, 0);
    host_rd("abort_word2", 2, 32'h1234);
    txn(1, 32'h1C, 32'h2, 0, 0, 1, 7, 32'h1);
    host_rd("collide_wr_word7", 7, 32'h2);
    host_wr(8, 32'h11);
    txn(0, 32'h20, 0, 32'h11, 0, 1, 8, 32'h22);
    host_rd("collide_rd_word8", 8, 32'h22);
    repeat (2) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_mem_server.md
MATRIX_MEM_SERVER -- requirements
Module: matrix_mem_server

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the backing store.
REQ-002 SHALL have parameter LAT, default 2, request-to-done latency in cycles; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_memory_transaction  input  1  request strobe from the multiply engine, level-sampled.
REQ-006 SHALL have port we  input  1  1 = write transaction, 0 = read transaction; sampled with the request.
REQ-007 SHALL have port address_in  input  32  byte address of the transaction; sampled with the request.
REQ-008 SHALL have port wdata  input  32  write data; sampled with the request.
REQ-009 SHALL have port rdata  output  32  read data returned to the engine.
REQ-010 SHALL have port done_memory_transaction  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  status of the last completed transaction; 1 = misaligned or out of range.
REQ-012 SHALL have ports host_we (input, 1), host_addr (input, 6 = clog2(DEPTH)), host_wdata (input, 32) and host_rdata (output, 32), forming a word-indexed preload/readback port.

Function
REQ-013 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 In IDLE with start_memory_transaction=1 at a rising edge, SHALL capture we, address_in and wdata, load the latency counter with LAT-1, and enter BUSY.
REQ-015 In BUSY, SHALL decrement the counter each cycle and enter DONE on the edge where the counter equals 0.
REQ-016 In DONE, SHALL assert done_memory_transaction for exactly one cycle and return to IDLE; done is high in the LAT+1-th cycle after the sampling edge.
REQ-017 SHALL ignore start_memory_transaction while in BUSY or DONE; a request level still high in IDLE after DONE SHALL start a new transaction (back-to-back period LAT+2 cycles).
REQ-018 SHALL derive the word index from address_in[31:2]; the transaction is valid iff address_in[1:0]=0 and the index is less than DEPTH.
REQ-019 For a valid read, SHALL update rdata with mem[index] on the edge entering DONE and hold rdata until the next completion.
REQ-020 For a valid write, SHALL write wdata to mem[index] on the edge entering DONE and leave rdata unchanged.
REQ-021 For an invalid transaction, SHALL perform no memory write, set rdata to 0, and set err=1 at DONE; a valid transaction SHALL set err=0 at DONE; err holds until the next completion.
REQ-022 host_we=1 SHALL write host_wdata to mem[host_addr] at the edge; host_rdata SHALL be registered, equal to mem[host_addr] one cycle later, with read-before-write ordering.
REQ-023 On a same-edge host write and transaction write to the same word, the transaction write SHALL win.
REQ-024 On a same-edge host write and transaction read of the same word, rdata SHALL return the old contents.

Reset
REQ-025 When rst_n=0, SHALL asynchronously force state=IDLE, counter=0, rdata=0, err=0, done_memory_transaction=0 and host_rdata=0.
REQ-026 Reset asserted mid-transaction SHALL abort it without any memory write and without a done pulse; memory contents SHALL NOT be cleared by reset.

Structure
REQ-027 SHALL place the FSM state encodings and the word-width constant (32) in the shared matrix package used by the multiply engine.
REQ-028 SHALL isolate the storage array in one sub-module, mem_dualport (two write ports with priority plus two read ports); all control SHALL stay in matrix_mem_server.

Verification
REQ-029 Host-write 0x0000_0005 to word 3; read request at address 0x0C with LAT=2 -> done pulses 3 cycles after the sampling edge, rdata=0x5, err=0.
REQ-030 Write request at 0x10 with wdata 0xDEAD_BEEF, then host_addr=4 -> host_rdata=0xDEADBEEF one cycle later.
REQ-031 Read at 0x0E (misaligned) and read at 0x100 (index 64) -> err=1, rdata=0, memory unchanged.
REQ-032 Request held high for 20 cycles with LAT=2 -> done pulses exactly every 4 cycles, each one cycle wide.
REQ-033 rst_n pulsed low one cycle after a write request is sampled at 0x08 -> no done pulse, word 2 unchanged, all outputs 0.
REQ-034 Same-edge host write of 0x1 and transaction write of 0x2 to word 7 -> word 7 reads 0x2.
